// File: rtl/bnn_pkg.sv
// Shared types and constants for the BNN inference scheduler.
package bnn_pkg;
   localparam int unsigned IMG_BITS       = 900;
   localparam int unsigned RESULT_W       = 4;
   localparam logic [3:0]  RESULT_TIMEOUT = 4'hF;

   typedef enum logic [1:0] {IDLE, GRANT, RUN, RESP} sched_state_t;
endpackage

// File: rtl/bnn_rr_arbiter.sv
// Combinational round-robin pick: first valid request at or after ptr, wrapping modulo NUM_REQ.
module bnn_rr_arbiter #(
   parameter int unsigned NUM_REQ = 2,
   localparam int unsigned IDX_W  = $clog2(NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   ptr,
   output logic [NUM_REQ-1:0] grant,
   output logic [IDX_W-1:0]   idx,
   output logic               any
);

   always_comb begin
      int unsigned cand;
      grant = '0;
      idx   = '0;
      any   = 1'b0;
      cand  = 0;
      for (int unsigned k = 0; k < NUM_REQ; k++) begin
         cand = (32'(ptr) + k) % NUM_REQ;
         if (!any && req[cand]) begin
            any = 1'b1;
            idx = IDX_W'(cand);
         end
      end
      if (any) grant[idx] = 1'b1;
   end

endmodule

// File: rtl/bnn_scheduler.sv
// Shares one bnn_top engine between NUM_REQ image sources (round-robin, one inference in flight).
// Optional RUN watchdog enabled by defining BNN_TIMEOUT_EN.
module bnn_scheduler #(
   parameter int unsigned NUM_REQ        = 2,
   parameter int unsigned IMG_BITS       = 900,
   parameter int unsigned RESULT_W       = 4,
   parameter int unsigned TIMEOUT_CYCLES = 4096
) (
   input  logic                         clk,
   input  logic                         rst,
   input  logic [NUM_REQ-1:0]           req_valid,
   input  logic [NUM_REQ*IMG_BITS-1:0]  req_img,
   output logic [NUM_REQ-1:0]           req_ready,
   output logic [NUM_REQ-1:0]           rsp_valid,
   output logic [RESULT_W-1:0]          rsp_result,
   output logic                         rsp_err,
   input  logic [NUM_REQ-1:0]           rsp_ack,
   output logic [IMG_BITS-1:0]          bnn_img,
   output logic                         bnn_start,
   input  logic [RESULT_W-1:0]          bnn_result,
   input  logic                         bnn_done,
   output logic                         busy
);
   import bnn_pkg::*;

   localparam int unsigned IDX_W = $clog2(NUM_REQ);

   sched_state_t        state_q, state_d;
   logic [IDX_W-1:0]    grant_q, rr_q, pick_idx;
   logic [NUM_REQ-1:0]  grant_oh_q, pick_oh;
   logic                pick_any;
   logic [IMG_BITS-1:0] img_q;
   logic [RESULT_W-1:0] result_q;
   logic                ack_hit;
   logic                timeout_hit;

   bnn_rr_arbiter #(
      .NUM_REQ(NUM_REQ)
   ) u_arb (
      .req   (req_valid),
      .ptr   (rr_q),
      .grant (pick_oh),
      .idx   (pick_idx),
      .any   (pick_any)
   );

   assign ack_hit = |(rsp_ack & grant_oh_q);

`ifdef BNN_TIMEOUT_EN
   localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

   logic [CNT_W-1:0] cnt_q;
   logic             err_q;

   // A real bnn_done on the expiry cycle takes priority over the watchdog.
   assign timeout_hit = (state_q == RUN) && !bnn_done &&
                        (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
         err_q <= 1'b0;
      end else begin
         if (state_q == GRANT) begin
            cnt_q <= '0;
            err_q <= 1'b0;
         end else if (state_q == RUN) begin
            cnt_q <= cnt_q + 1'b1;
            if (bnn_done || timeout_hit) err_q <= timeout_hit;
         end
      end
   end

   assign rsp_err = err_q;
`else
   assign timeout_hit = 1'b0;
   assign rsp_err     = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (pick_any) state_d = GRANT;
         GRANT:   state_d = RUN;
         RUN:     if (bnn_done || timeout_hit) state_d = RESP;
         RESP:    if (ack_hit) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         grant_q    <= '0;
         grant_oh_q <= '0;
         rr_q       <= '0;
         img_q      <= '0;
         result_q   <= '0;
      end else begin
         state_q <= state_d;
         if (state_q == IDLE && pick_any) begin
            grant_q    <= pick_idx;
            grant_oh_q <= pick_oh;
         end
         if (state_q == GRANT) img_q <= req_img[int'(grant_q)*IMG_BITS +: IMG_BITS];
         if (state_q == RUN) begin
            if (bnn_done)         result_q <= bnn_result;
            else if (timeout_hit) result_q <= '1;
         end
         if (state_q == RESP && ack_hit) begin
            rr_q <= (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
         end
      end
   end

   assign req_ready  = (state_q == GRANT) ? grant_oh_q : '0;
   assign rsp_valid  = (state_q == RESP) ? grant_oh_q : '0;
   assign rsp_result = result_q;
   assign bnn_img    = img_q;
   assign bnn_start  = (state_q == RUN);
   assign busy       = (state_q != IDLE);

endmodule
